// File: rtl/stack_pkg.sv
// Shared constants and helpers for the parametrised data/return stack.
package stack_pkg;

    // Stack-pointer delta encodings, compatible with the legacy 2-bit field
    localparam int DELTA_NOP   = 0;
    localparam int DELTA_PUSH  = 1;
    localparam int DELTA_POP   = -1;
    localparam int DELTA_DROP2 = -2;

    // Bits needed to represent a live depth of 0..depth
    function automatic int unsigned depth_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/stack_mem.sv
// Stack storage: one synchronous write port, two asynchronous read ports.
// Indexed by stack position minus one (position 1 is the bottom entry).
module stack_mem #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 512,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wd,
    input  logic [AW-1:0]    raddr_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_a_c,
    output logic [WIDTH-1:0] rdata_b_c
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wd;
        end
    end

    // Asynchronous reads used to refill the top-of-stack registers on pops
    assign rdata_a_c = mem[raddr_a];
    assign rdata_b_c = mem[raddr_b];

endmodule

// File: rtl/ram_stack4.sv
// Parametrised CPU data/return stack with registered top/next-of-stack,
// live depth tracking, full/empty status and sticky over/underflow flags.
module ram_stack4 import stack_pkg::*; #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned DEPTH   = 512,
    parameter int unsigned DELTA_W = 2,
    parameter int unsigned DPTH_W  = depth_w(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [DELTA_W-1:0] delta,
    input  logic [WIDTH-1:0]   wd,
    input  logic               err_clr,
    output logic [WIDTH-1:0]   rd,
    output logic [WIDTH-1:0]   rd_next,
    output logic [DPTH_W-1:0]  depth,
    output logic               empty,
    output logic               full,
    output logic               ovf,
    output logic               unf
);

    localparam int unsigned AW = $clog2(DEPTH);
    // Signed arithmetic width wide enough for depth + delta without wrap
    localparam int unsigned SW = ((DPTH_W > DELTA_W) ? DPTH_W : DELTA_W) + 2;

    logic signed [SW-1:0] cur_s;
    logic signed [SW-1:0] delta_s;
    logic signed [SW-1:0] nd_s;
    logic                 ovf_c;
    logic                 unf_c;
    logic                 op_ok_c;
    logic                 nd_ge1_c;
    logic                 nd_ge2_c;
    logic                 mem_we_c;
    logic [AW-1:0]        waddr_c;
    logic [AW-1:0]        ra_top_c;
    logic [AW-1:0]        ra_next_c;
    logic [WIDTH-1:0]     mem_top_c;
    logic [WIDTH-1:0]     mem_next_c;
    logic [WIDTH-1:0]     top_n_c;
    logic [WIDTH-1:0]     next_n_c;

    // Every written entry is also kept in the array, so any pop depth can
    // refill both registers from it in the same edge.
    stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk       (clk),
        .we        (mem_we_c),
        .waddr     (waddr_c),
        .wd        (wd),
        .raddr_a   (ra_top_c),
        .raddr_b   (ra_next_c),
        .rdata_a_c (mem_top_c),
        .rdata_b_c (mem_next_c)
    );

    // Pointer arithmetic, error detection and next top/next-of-stack values
    always_comb begin
        cur_s    = $signed(SW'(depth));
        delta_s  = SW'($signed(delta));
        nd_s     = cur_s + delta_s;
        unf_c    = nd_s[SW-1];
        ovf_c    = !unf_c && (nd_s > $signed(SW'(DEPTH)));
        op_ok_c  = !ovf_c && !unf_c;
        nd_ge1_c = op_ok_c && (nd_s != '0);
        nd_ge2_c = op_ok_c && (nd_s > $signed(SW'(1)));

        mem_we_c  = we && nd_ge1_c;
        waddr_c   = AW'(nd_s - $signed(SW'(1)));
        ra_top_c  = nd_ge1_c ? AW'(nd_s - $signed(SW'(1))) : '0;
        ra_next_c = nd_ge2_c ? AW'(nd_s - $signed(SW'(2))) : '0;

        top_n_c = mem_top_c;
        if (delta_s == $signed(SW'(DELTA_NOP))) begin
            top_n_c = rd;
        end else if (delta_s == $signed(SW'(DELTA_POP))) begin
            top_n_c = rd_next;
        end
        if (we) begin
            top_n_c = wd;
        end
        if (!nd_ge1_c) begin
            top_n_c = '0;
        end

        next_n_c = mem_next_c;
        if (delta_s == $signed(SW'(DELTA_NOP))) begin
            next_n_c = rd_next;
        end else if (delta_s == $signed(SW'(DELTA_PUSH))) begin
            next_n_c = rd;
        end
        if (!nd_ge2_c) begin
            next_n_c = '0;
        end
    end

    // Architectural state: suppressed entirely on over/underflow
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            depth   <= '0;
            rd      <= '0;
            rd_next <= '0;
            empty   <= 1'b1;
            full    <= 1'b0;
            ovf     <= 1'b0;
            unf     <= 1'b0;
        end else begin
            if (op_ok_c) begin
                depth   <= DPTH_W'(nd_s);
                rd      <= top_n_c;
                rd_next <= next_n_c;
                empty   <= !nd_ge1_c;
                full    <= (nd_s == $signed(SW'(DEPTH)));
            end
            // A new error outranks a simultaneous clear
            ovf <= ovf_c || (ovf && !err_clr);
            unf <= unf_c || (unf && !err_clr);
        end
    end

endmodule

// File: tb/tb_ram_stack4.sv
// Self-checking bench for ram_stack4: directed steps plus random traffic
// compared against a position-indexed array model of the stack.
module tb_ram_stack4;

    localparam int WIDTH   = 16;
    localparam int DEPTH   = 16;
    localparam int DELTA_W = 2;
    localparam int DPTH_W  = $clog2(DEPTH + 1);

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               we = 1'b0;
    logic [DELTA_W-1:0] delta = '0;
    logic [WIDTH-1:0]   wd = '0;
    logic               err_clr = 1'b0;
    logic [WIDTH-1:0]   rd;
    logic [WIDTH-1:0]   rd_next;
    logic [DPTH_W-1:0]  depth;
    logic               empty;
    logic               full;
    logic               ovf;
    logic               unf;

    int tests = 0;
    int fails = 0;

    // Reference model: value and "defined" flag per stack position 1..DEPTH
    int         mdepth = 0;
    logic [WIDTH-1:0] mval [1:DEPTH];
    bit         mknown [1:DEPTH];
    bit         movf = 1'b0;
    bit         munf = 1'b0;

    ram_stack4 #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .DELTA_W (DELTA_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .delta   (delta),
        .wd      (wd),
        .err_clr (err_clr),
        .rd      (rd),
        .rd_next (rd_next),
        .depth   (depth),
        .empty   (empty),
        .full    (full),
        .ovf     (ovf),
        .unf     (unf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_check(input string tag);
        check({tag, ".depth"}, 32'(depth), 32'(mdepth));
        check({tag, ".empty"}, 32'(empty), 32'(mdepth == 0));
        check({tag, ".full"},  32'(full),  32'(mdepth == DEPTH));
        check({tag, ".ovf"},   32'(ovf),   32'(movf));
        check({tag, ".unf"},   32'(unf),   32'(munf));
        if (mdepth == 0)
            check({tag, ".rd"}, 32'(rd), 32'd0);
        else if (mknown[mdepth])
            check({tag, ".rd"}, 32'(rd), 32'(mval[mdepth]));
        if (mdepth < 2)
            check({tag, ".rd_next"}, 32'(rd_next), 32'd0);
        else if (mknown[mdepth-1])
            check({tag, ".rd_next"}, 32'(rd_next), 32'(mval[mdepth-1]));
    endtask

    // Drive one operation, let it take effect at the edge, update model, compare
    task automatic step(input string tag, input bit w, input int d,
                        input logic [WIDTH-1:0] data, input bit clr);
        int nd;
        we      = w;
        delta   = DELTA_W'(d);
        wd      = data;
        err_clr = clr;
        @(posedge clk);
        #1;
        nd = mdepth + d;
        if (clr) begin
            movf = 1'b0;
            munf = 1'b0;
        end
        if (nd > DEPTH) begin
            movf = 1'b1;
        end else if (nd < 0) begin
            munf = 1'b1;
        end else begin
            for (int p = mdepth + 1; p <= nd; p++) mknown[p] = 1'b0;
            if (w && nd > 0) begin
                mval[nd]   = data;
                mknown[nd] = 1'b1;
            end
            mdepth = nd;
        end
        model_check(tag);
    endtask

    initial begin
        for (int p = 1; p <= DEPTH; p++) begin
            mval[p]   = '0;
            mknown[p] = 1'b0;
        end

        // Reset values while held in reset
        #12;
        model_check("reset");
        @(negedge clk);
        rst = 1'b1;

        // Three pushes
        step("push1", 1'b1, 1, 16'd1, 1'b0);
        step("push2", 1'b1, 1, 16'd2, 1'b0);
        step("push3", 1'b1, 1, 16'd3, 1'b0);
        check("p3.rd", 32'(rd), 32'd3);
        check("p3.rd_next", 32'(rd_next), 32'd2);
        check("p3.depth", 32'(depth), 32'd3);
        check("p3.empty", 32'(empty), 32'd0);

        // Binary op: pop then overwrite new top; then drop two
        step("binop", 1'b1, -1, 16'h0055, 1'b0);
        check("binop.rd", 32'(rd), 32'h55);
        check("binop.rd_next", 32'(rd_next), 32'd1);
        check("binop.depth", 32'(depth), 32'd2);
        step("drop2", 1'b0, -2, 16'h0, 1'b0);
        check("drop2.depth", 32'(depth), 32'd0);
        check("drop2.empty", 32'(empty), 32'd1);
        check("drop2.rd", 32'(rd), 32'd0);
        check("drop2.rd_next", 32'(rd_next), 32'd0);

        // Fill to DEPTH, then one push too many
        for (int i = 1; i <= DEPTH; i++) step("fill", 1'b1, 1, WIDTH'(i), 1'b0);
        step("over", 1'b1, 1, 16'hAAAA, 1'b0);
        check("over.full", 32'(full), 32'd1);
        check("over.ovf", 32'(ovf), 32'd1);
        check("over.depth", 32'(depth), 32'(DEPTH));
        check("over.rd", 32'(rd), 32'(DEPTH));
        step("pop_full", 1'b0, -1, 16'h0, 1'b0);
        check("pop_full.rd", 32'(rd), 32'(DEPTH - 1));
        check("pop_full.ovf", 32'(ovf), 32'd1);
        step("clr_ovf", 1'b0, 0, 16'h0, 1'b1);
        check("clr_ovf.ovf", 32'(ovf), 32'd0);

        // Drain to empty
        while (mdepth >= 2) step("drain", 1'b0, -2, 16'h0, 1'b0);
        if (mdepth == 1) step("drain1", 1'b0, -1, 16'h0, 1'b0);

        // Underflow and error clear priority
        step("under", 1'b0, -1, 16'h0, 1'b0);
        check("under.unf", 32'(unf), 32'd1);
        check("under.depth", 32'(depth), 32'd0);
        step("clr_vs_err", 1'b0, -2, 16'h0, 1'b1);
        check("clr_vs_err.unf", 32'(unf), 32'd1);
        step("clr_unf", 1'b0, 0, 16'h0, 1'b1);
        check("clr_unf.unf", 32'(unf), 32'd0);

        // Write with resulting depth zero is discarded, not an error
        step("wr_empty", 1'b1, 0, 16'h1234, 1'b0);
        check("wr_empty.rd", 32'(rd), 32'd0);
        check("wr_empty.unf", 32'(unf), 32'd0);

        // Asynchronous reset between edges at depth 5
        for (int i = 0; i < 5; i++) step("pre_rst", 1'b1, 1, WIDTH'(16'h10 + i), 1'b0);
        check("pre_rst.depth", 32'(depth), 32'd5);
        we    = 1'b0;
        delta = '0;
        #2;
        rst = 1'b0;
        #1;
        mdepth = 0;
        movf   = 1'b0;
        munf   = 1'b0;
        model_check("async_rst");
        @(negedge clk);
        rst = 1'b1;
        step("post_rst", 1'b1, 1, 16'd7, 1'b0);
        check("post_rst.rd", 32'(rd), 32'd7);
        check("post_rst.depth", 32'(depth), 32'd1);

        // Random traffic in alternating fill-biased and drain-biased phases
        for (int cyc = 0; cyc < 10000; cyc++) begin
            int r;
            int d;
            bit up;
            up = ((cyc / 300) % 2) == 0;
            r  = int'($urandom_range(0, 99));
            if (up) d = (r < 55) ? 1 : (r < 75) ? 0 : (r < 90) ? -1 : -2;
            else    d = (r < 25) ? 1 : (r < 45) ? 0 : (r < 75) ? -1 : -2;
            step("rand", ($urandom_range(0, 99) < 75), d, WIDTH'($urandom),
                 ($urandom_range(0, 99) < 4));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
